// File: rtl/ibex_id_hazard_scoreboard_if.sv
// ibex_id_hazard_scoreboard_if: issue and writeback bundle between the decoder side
// (master) and the hazard scoreboard (slave).  Rev 1.0
`default_nettype none

interface ibex_id_hazard_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int NUM_RPORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                       flush_i;
  logic                       issue_valid_i;
  logic                       issue_ready_o;
  logic                       issue_we_i;
  logic                       issue_long_i;
  logic [AW-1:0]              issue_waddr_i;
  logic [NUM_RPORTS-1:0]      issue_ren_i;
  logic [NUM_RPORTS*AW-1:0]   issue_raddr_i;
  logic                       wb_valid_i;
  logic [AW-1:0]              wb_waddr_i;
  logic                       stall_o;
  logic                       busy_o;
  logic                       wb_err_o;

  modport master (
    output flush_i, issue_valid_i, issue_we_i, issue_long_i, issue_waddr_i,
           issue_ren_i, issue_raddr_i, wb_valid_i, wb_waddr_i,
    input  issue_ready_o, stall_o, busy_o, wb_err_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_we_i, issue_long_i, issue_waddr_i,
           issue_ren_i, issue_raddr_i, wb_valid_i, wb_waddr_i,
    output issue_ready_o, stall_o, busy_o, wb_err_o
  );
endinterface

`default_nettype wire

// File: rtl/ibex_id_hazard_scoreboard.sv
// ibex_id_hazard_scoreboard: per-register pending-writeback counters that hold off
// issue on RAW hazards and on WAW counter overflow.  Rev 1.0
`default_nettype none

module ibex_id_hazard_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int NUM_RPORTS      = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int WB_BYPASS       = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ibex_id_hazard_scoreboard_if.slave  sb
);

  localparam int            AW      = $clog2(NUM_REGS);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]         cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_RPORTS-1:0] port_hazard;
  logic                  stall;
  logic                  issue_tracked;
  logic                  full;
  logic                  ready;
  logic                  accept;
  logic                  wb_err_d;
  logic                  wb_err_q;

  // A source is released early only when this writeback retires its last pending write.
  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [AW-1:0] raddr;
    logic          bypass;
    assign raddr  = sb.issue_raddr_i[p*AW +: AW];
    assign bypass = (WB_BYPASS != 0) && sb.wb_valid_i &&
                    (sb.wb_waddr_i == raddr) && (cnt[raddr] == CNT_ONE);
    assign port_hazard[p] = sb.issue_ren_i[p] && (raddr != '0) &&
                            (cnt[raddr] != '0) && !bypass;
  end

  assign stall         = |port_hazard;
  assign issue_tracked = sb.issue_we_i && sb.issue_long_i && (sb.issue_waddr_i != '0);
  assign full          = issue_tracked && (cnt[sb.issue_waddr_i] == CNT_MAX);
  assign ready         = !sb.flush_i && !stall && !full;
  assign accept        = sb.issue_valid_i && ready;

  assign cnt[0]     = '0;
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic          inc;
    logic          dec;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    assign inc = accept && issue_tracked && (sb.issue_waddr_i == AW'(r));
    assign dec = sb.wb_valid_i && (sb.wb_waddr_i == AW'(r)) && (cnt_q != '0);

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || sb.flush_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt[r]     = cnt_q;
    assign pending[r] = (cnt_q != '0);
  end

  // Retiring a write that was never issued; x0 writebacks are harmless.
  assign wb_err_d = !sb.flush_i && sb.wb_valid_i && (sb.wb_waddr_i != '0) &&
                    (cnt[sb.wb_waddr_i] == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign sb.issue_ready_o = ready;
  assign sb.stall_o       = stall;
  assign sb.busy_o        = |pending;
  assign sb.wb_err_o      = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_id_hazard_scoreboard.sv
// tb_ibex_id_hazard_scoreboard: directed vector table plus reset-mid-stream sequence
// for the hazard scoreboard with default parameters.  Rev 1.0
`default_nettype none

module tb_ibex_id_hazard_scoreboard;

  typedef struct packed {
    logic       fl;
    logic       v;
    logic       we;
    logic       lg;
    logic [4:0] wa;
    logic [1:0] ren;
    logic [4:0] r0;
    logic [4:0] r1;
    logic       wbv;
    logic [4:0] wba;
    logic       rdy;
    logic       stl;
    logic       bsy;
    logic       err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ibex_id_hazard_scoreboard_if #(.NUM_REGS(32), .NUM_RPORTS(2)) sb_if ();

  ibex_id_hazard_scoreboard #(
    .NUM_REGS       (32),
    .NUM_RPORTS     (2),
    .MAX_OUTSTANDING(2),
    .WB_BYPASS      (1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sb   (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic fl, input logic v, input logic we, input logic lg,
                              input int wa, input int ren, input int r0, input int r1,
                              input logic wbv, input int wba, input logic rdy,
                              input logic stl, input logic bsy, input logic err);
    vec_t t;
    t.fl = fl; t.v = v; t.we = we; t.lg = lg; t.wa = 5'(wa);
    t.ren = 2'(ren); t.r0 = 5'(r0); t.r1 = 5'(r1); t.wbv = wbv; t.wba = 5'(wba);
    t.rdy = rdy; t.stl = stl; t.bsy = bsy; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    sb_if.flush_i       = t.fl;
    sb_if.issue_valid_i = t.v;
    sb_if.issue_we_i    = t.we;
    sb_if.issue_long_i  = t.lg;
    sb_if.issue_waddr_i = t.wa;
    sb_if.issue_ren_i   = t.ren;
    sb_if.issue_raddr_i = {t.r1, t.r0};
    sb_if.wb_valid_i    = t.wbv;
    sb_if.wb_waddr_i    = t.wba;
  endtask

  // Drive on the falling edge, compare 1 ns later, the rising edge follows.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, ".ready"}, sb_if.issue_ready_o, t.rdy);
    chk({tag, ".stall"}, sb_if.stall_o,       t.stl);
    chk({tag, ".busy"},  sb_if.busy_o,        t.bsy);
    chk({tag, ".wb_err"}, sb_if.wb_err_o,     t.err);
  endtask

  vec_t vecs[$];

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));

    //            fl v we lg wa ren r0 r1 wbv wba   rdy stl bsy err
    vecs.push_back(mk(0,0,0,0, 0,0, 0, 0,0, 0,  1,0,0,0)); // reset/idle
    vecs.push_back(mk(0,1,1,1, 5,0, 0, 0,0, 0,  1,0,0,0)); // long write x5
    vecs.push_back(mk(0,1,0,0, 0,1, 5, 0,0, 0,  0,1,1,0)); // RAW on x5
    vecs.push_back(mk(0,1,0,0, 0,1, 5, 0,1, 5,  1,0,1,0)); // bypass release
    vecs.push_back(mk(0,0,0,0, 0,0, 0, 0,0, 0,  1,0,0,0));
    vecs.push_back(mk(0,1,1,1, 7,0, 0, 0,0, 0,  1,0,0,0)); // x7 cnt 0->1
    vecs.push_back(mk(0,1,1,1, 7,0, 0, 0,0, 0,  1,0,1,0)); // x7 cnt 1->2
    vecs.push_back(mk(0,1,1,1, 7,0, 0, 0,0, 0,  0,0,1,0)); // full
    vecs.push_back(mk(0,1,1,1, 7,1, 7, 0,1, 7,  0,1,1,0)); // full + no bypass at cnt 2
    vecs.push_back(mk(0,1,1,1, 7,0, 0, 0,0, 0,  1,0,1,0)); // cnt 1 -> accepted
    vecs.push_back(mk(0,1,0,0, 0,2, 0, 7,1, 7,  0,1,1,0)); // port1 stall, cnt 2->1
    vecs.push_back(mk(0,1,0,0, 0,2, 0, 7,1, 7,  1,0,1,0)); // port1 bypass, cnt 1->0
    vecs.push_back(mk(0,1,0,0, 0,2, 0, 7,0, 0,  1,0,0,0));
    vecs.push_back(mk(0,1,1,1, 0,0, 0, 0,0, 0,  1,0,0,0)); // long write x0
    vecs.push_back(mk(0,1,1,0, 3,0, 0, 0,0, 0,  1,0,0,0)); // short write x3
    vecs.push_back(mk(0,1,0,0, 0,3, 0, 3,0, 0,  1,0,0,0)); // reads x0,x3
    vecs.push_back(mk(0,1,1,1, 9,0, 0, 0,0, 0,  1,0,0,0)); // x9 cnt 1
    vecs.push_back(mk(0,0,0,0, 0,0, 0, 0,1, 4,  1,0,1,0)); // wb to idle x4
    vecs.push_back(mk(0,0,0,0, 0,1, 4, 0,0, 0,  1,0,1,1)); // err pulse, x4 still 0
    vecs.push_back(mk(0,0,0,0, 0,1, 9, 0,0, 0,  0,1,1,0)); // pulse gone, x9 kept
    vecs.push_back(mk(0,1,0,0, 0,1, 9, 0,1, 9,  1,0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0, 0,1, 0,  1,0,0,0)); // wb x0 no error
    vecs.push_back(mk(0,0,0,0, 0,0, 0, 0,0, 0,  1,0,0,0));
    vecs.push_back(mk(0,1,1,1, 2,0, 0, 0,0, 0,  1,0,0,0));
    vecs.push_back(mk(0,1,1,1,31,0, 0, 0,0, 0,  1,0,1,0));
    vecs.push_back(mk(1,1,1,1,10,0, 0, 0,1, 2,  0,0,1,0)); // flush + issue + wb
    vecs.push_back(mk(0,1,0,0, 0,3, 2,31,0, 0,  1,0,0,0)); // all cleared
    vecs.push_back(mk(1,0,0,0, 0,0, 0, 0,1, 6,  0,0,0,0)); // flush masks wb error
    vecs.push_back(mk(0,0,0,0, 0,0, 0, 0,0, 0,  1,0,0,0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-stream, with an issue and an erroneous writeback in the reset cycle.
    apply(mk(0,1,1,1, 2,0,0,0,0,0, 1,0,0,0), "rst_a");
    apply(mk(0,1,1,1,31,0,0,0,0,0, 1,0,1,0), "rst_b");
    @(negedge clk);
    drive(mk(0,1,1,1,10,0,0,0,1,4, 0,0,0,0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    #1;
    chk("rst_c.busy",   sb_if.busy_o,   1'b0);
    chk("rst_c.wb_err", sb_if.wb_err_o, 1'b0);
    apply(mk(0,1,0,0, 0,3, 2,10,0,0, 1,0,0,0), "rst_d");
    apply(mk(0,0,0,0, 0,1,31, 0,0,0, 1,0,0,0), "rst_e");

    // Reset wins over a simultaneous flush and issue.
    apply(mk(0,1,1,1, 5,0,0,0,0,0, 1,0,0,0), "rst_f");
    @(negedge clk);
    drive(mk(1,1,1,1,6,0,0,0,0,0, 0,0,0,0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0,0,0,0, 0,3, 5, 6,0,0, 1,0,0,0), "rst_g");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
